// File: rtl/seq_pat_pkg.sv
// Shared types and elaboration-time helpers for the serial pattern detector.
// The next-prefix table and border length are computed once from PATTERN/PAT_W.
package seq_pat_pkg;

    localparam int MAX_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // Entry {k,b} holds the matched-prefix length after bit b arrives in TRACK(k);
    // a value equal to PAT_W means the pattern just completed.
    typedef logic [2*MAX_W-1:0][4:0] next_tbl_t;

    function automatic int border_len(input logic [MAX_W-1:0] pat, input int w);
        int best;
        bit ok;
        best = 0;
        for (int l = 1; l < w; l++) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                if (pat[4'(w-1-i)] != pat[4'(l-1-i)])
                    ok = 1'b0;
            end
            if (ok)
                best = l;
        end
        return best;
    endfunction

    function automatic int next_len(input logic [MAX_W-1:0] pat, input int w,
                                    input int k, input logic b);
        int best;
        int p;
        bit ok;
        logic sbit;
        best = 0;
        for (int l = 1; l <= k + 1; l++) begin
            if (l <= w) begin
                ok = 1'b1;
                for (int i = 0; i < l; i++) begin
                    p = k + 1 - l + i;
                    sbit = (p < k) ? pat[4'(w-1-p)] : b;
                    if (sbit != pat[4'(w-1-i)])
                        ok = 1'b0;
                end
                if (ok)
                    best = l;
            end
        end
        return best;
    endfunction

    function automatic next_tbl_t build_table(input logic [MAX_W-1:0] pat, input int w);
        next_tbl_t t;
        t = '0;
        for (int k = 0; k < w; k++) begin
            for (int b = 0; b < 2; b++) begin
                t[5'(2*k+b)] = 5'(next_len(pat, w, k, 1'(b)));
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/seq_pat_counter.sv
// Saturating match counter with synchronous clear; sat is high while the count is all-ones.
module seq_pat_counter
    import seq_pat_pkg::*;
#(
    parameter int W = 8
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (clr)
            cnt_q <= '0;
        else if (inc && !(&cnt_q))
            cnt_q <= cnt_q + 1'b1;
    end

    assign cnt = cnt_q;
    assign sat = &cnt_q;

endmodule

// File: rtl/seq_pattern_fsm.sv
// Parametrised serial pattern detector (KMP-style prefix tracking, registered match pulse).
// Define SEQ_PAT_CNT_EN to add the saturating match counter and its match_cnt/cnt_sat ports.
module seq_pattern_fsm
    import seq_pat_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_valid,
    input  logic                     din,
    input  logic                     clr,
    output logic                     match,
    output logic [$clog2(PAT_W)-1:0] prefix_len
`ifdef SEQ_PAT_CNT_EN
    ,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     cnt_sat
`endif
);

    localparam int                PL_W     = $clog2(PAT_W);
    localparam next_tbl_t         NEXT_TBL = build_table(16'(PATTERN), PAT_W);
    localparam logic [PL_W-1:0]   BORDER   = PL_W'(border_len(16'(PATTERN), PAT_W));
    localparam logic [4:0]        FULL     = 5'(PAT_W);

    typedef logic [CNT_W-1:0] cnt_t;

    state_t          state_q;
    state_t          state_d;
    logic [PL_W-1:0] prefix_q;
    logic [PL_W-1:0] prefix_d;
    logic            match_q;
    logic            match_d;
    logic [4:0]      step;

    assign step = NEXT_TBL[5'({prefix_q, din})];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            prefix_q <= '0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prefix_q <= prefix_d;
            match_q  <= match_d;
        end
    end

    // clr wins over an accepted bit; a completed pattern restarts from the border or from zero.
    always_comb begin
        state_d  = state_q;
        prefix_d = prefix_q;
        match_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d  = ST_TRACK;
                prefix_d = '0;
            end
            ST_TRACK: begin
                if (clr) begin
                    prefix_d = '0;
                end else if (din_valid) begin
                    if (step == FULL) begin
                        match_d  = 1'b1;
                        prefix_d = OVERLAP ? BORDER : '0;
                    end else begin
                        prefix_d = step[PL_W-1:0];
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                prefix_d = '0;
            end
        endcase
    end

    assign match      = match_q;
    assign prefix_len = prefix_q;

`ifdef SEQ_PAT_CNT_EN
    seq_pat_counter #(
        .W   ($bits(cnt_t))
    ) u_counter (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (match_d),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );
`endif

endmodule
